counter_phase_sequencer: RTL and testbench



---
 rtl/counter_seq_pkg.sv | 15 +
 rtl/counter_step_unit.sv | 26 ++
 rtl/counter_phase_sequencer.sv | 128 ++++++++++++
 tb/tb_counter_phase_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - mode codes and FSM state encoding for the counter phase sequencer
package counter_seq_pkg;

    localparam logic [1:0] MODE_UP     = 2'd0;
    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_DOUBLE = 2'd2;
    localparam logic [1:0] MODE_FREEZE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/counter_step_unit.sv
// rtl/counter_step_unit.sv - combinational next-count for up/down/double/freeze modes with hold enable
module counter_step_unit
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [1:0]       mode,
    input  logic             hold,
    output logic [WIDTH-1:0] next_count
);

    // Modulo-2**WIDTH step selected by mode; hold overrides every mode
    always_comb begin
        next_count = count;
        if (!hold) begin
            case (mode)
                MODE_UP:     next_count = count + WIDTH'(1);
                MODE_DOWN:   next_count = count - WIDTH'(1);
                MODE_DOUBLE: next_count = count + WIDTH'(2);
                default:     next_count = count;
            endcase
        end
    end

endmodule

// File: rtl/counter_phase_sequencer.sv
// rtl/counter_phase_sequencer.sv - phase-table scheduler for a shared counter; optional COUNTER_SEQ_LOOP_EN adds looping
module counter_phase_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int PHASES = 4,
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_mode,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              start,
    input  logic              abort,
`ifdef COUNTER_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] phase,
    output logic [WIDTH-1:0]  count
);

    seq_state_t        state;
    logic [1:0]        mode_tab [PHASES];
    logic [LEN_W-1:0]  len_tab  [PHASES];
    logic [LEN_W-1:0]  rem;
    logic [WIDTH-1:0]  next_count;
    logic              step_hold;
    logic [ADDR_W-1:0] next_phase;
    logic              last_phase;

    // A zero-length phase still occupies one cycle
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
        return (l == '0) ? LEN_W'(1) : l;
    endfunction

    // Zero-length phases freeze the counter whatever their mode
    always_comb begin
        step_hold  = (len_tab[phase] == '0);
        next_phase = phase + ADDR_W'(1);
        last_phase = (phase == ADDR_W'(PHASES - 1));
    end

    counter_step_unit #(.WIDTH(WIDTH)) u_step (
        .count      (count),
        .mode       (mode_tab[phase]),
        .hold       (step_hold),
        .next_count (next_count)
    );

    // Phase table, rem counter and IDLE/RUN/DONE control with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            phase <= '0;
            count <= '0;
            rem   <= '0;
            for (int i = 0; i < PHASES; i++) begin
                mode_tab[i] <= MODE_FREEZE;
                len_tab[i]  <= '0;
            end
        end else begin
            done <= 1'b0;
            // The table is frozen while a sequence is running
            if (cfg_we && (state != ST_RUN) && (32'(cfg_addr) < PHASES)) begin
                mode_tab[cfg_addr] <= cfg_mode;
                len_tab[cfg_addr]  <= cfg_len;
            end
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        count <= '0;
                        phase <= '0;
                        rem   <= eff_len(len_tab[0]);
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= next_count;
                        if (rem == LEN_W'(1)) begin
                            if (last_phase) begin
`ifdef COUNTER_SEQ_LOOP_EN
                                if (loop) begin
                                    phase <= '0;
                                    rem   <= eff_len(len_tab[0]);
                                    done  <= 1'b1;
                                end else begin
                                    state <= ST_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
`else
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
`endif
                            end else begin
                                phase <= next_phase;
                                rem   <= eff_len(len_tab[next_phase]);
                            end
                        end else begin
                            rem <= rem - LEN_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_phase_sequencer.sv
// tb/tb_counter_phase_sequencer.sv - randomized self-checking bench for counter_phase_sequencer
module tb_counter_phase_sequencer;

    localparam int WIDTH  = 8;
    localparam int PHASES = 4;
    localparam int ADDR_W = 2;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [1:0]        cfg_mode = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              loop = 1'b0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] phase;
    logic [WIDTH-1:0]  count;

    int checks = 0;
    int errors = 0;

    // Reference table held by the bench
    int m_mode [PHASES];
    int m_len  [PHASES];

    always #5 clk = ~clk;

    counter_phase_sequencer #(
        .WIDTH(WIDTH), .PHASES(PHASES), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_mode (cfg_mode),
        .cfg_len  (cfg_len),
        .start    (start),
        .abort    (abort),
`ifdef COUNTER_SEQ_LOOP_EN
        .loop     (loop),
`endif
        .busy     (busy),
        .done     (done),
        .phase    (phase),
        .count    (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < PHASES; i++) begin
            m_mode[i] = 3;
            m_len[i]  = 0;
        end
    endtask

    // Ordered list of the phase index owning each RUN step
    function automatic int step_phase(input int s);
        int acc = 0;
        for (int p = 0; p < PHASES; p++) begin
            acc += (m_len[p] == 0) ? 1 : m_len[p];
            if (s < acc) return p;
        end
        return PHASES - 1;
    endfunction

    function automatic int total_steps();
        int acc = 0;
        for (int p = 0; p < PHASES; p++) acc += (m_len[p] == 0) ? 1 : m_len[p];
        return acc;
    endfunction

    function automatic int delta_of(input int p);
        if (m_len[p] == 0) return 0;
        case (m_mode[p])
            0: return 1;
            1: return -1;
            2: return 2;
            default: return 0;
        endcase
    endfunction

    // Counter value after n RUN steps; steps wrap over the table when looping
    function automatic int model_count(input int n);
        int c = 0;
        int s_tot = total_steps();
        for (int s = 0; s < n; s++) c = (c + delta_of(step_phase(s % s_tot)) + 256) % 256;
        return c;
    endfunction

    task automatic cfg_write(input int addr, input int mode, input int len);
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(addr);
        cfg_mode = 2'(mode);
        cfg_len  = LEN_W'(len);
        tick();
        cfg_we = 1'b0;
        m_mode[addr] = mode;
        m_len[addr]  = len;
    endtask

    // Runs one sequence from IDLE; abort_at<0 means no abort, otherwise abort is
    // sampled after abort_at RUN edges. noise drives start/cfg_we during RUN.
    task automatic run_seq(input string name, input int abort_at, input bit noise);
        int s_tot = total_steps();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({name, "_entry_busy"}, 32'(busy), 1);
        check_eq({name, "_entry_count"}, 32'(count), 0);
        check_eq({name, "_entry_phase"}, 32'(phase), 0);
        for (int j = 1; j <= s_tot; j++) begin
            if (noise) begin
                start    = 1'($urandom);
                cfg_we   = 1'($urandom);
                cfg_addr = ADDR_W'($urandom);
                cfg_mode = 2'($urandom);
                cfg_len  = LEN_W'($urandom_range(0, 9));
            end
            if (abort_at == j - 1) begin
                abort = 1'b1;
                tick();
                abort  = 1'b0;
                start  = 1'b0;
                cfg_we = 1'b0;
                check_eq({name, "_abort_busy"}, 32'(busy), 0);
                check_eq({name, "_abort_done"}, 32'(done), 0);
                check_eq({name, "_abort_count"}, 32'(count), 32'(model_count(j - 1)));
                check_eq({name, "_abort_phase"}, 32'(phase), 32'(step_phase(j - 1)));
                tick();
                check_eq({name, "_abort_idle_done"}, 32'(done), 0);
                check_eq({name, "_abort_idle_busy"}, 32'(busy), 0);
                return;
            end
            tick();
            start  = 1'b0;
            cfg_we = 1'b0;
            check_eq({name, "_busy"}, 32'(busy), (j < s_tot) ? 1 : 0);
            check_eq({name, "_done"}, 32'(done), (j == s_tot) ? 1 : 0);
            check_eq({name, "_count"}, 32'(count), 32'(model_count(j)));
            check_eq({name, "_phase"}, 32'(phase), (j < s_tot) ? 32'(step_phase(j)) : 32'(PHASES - 1));
        end
        tick();
        check_eq({name, "_after_done"}, 32'(done), 0);
        check_eq({name, "_after_busy"}, 32'(busy), 0);
        check_eq({name, "_after_count"}, 32'(count), 32'(model_count(s_tot)));
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_phase", 32'(phase), 0);
        check_eq("rst_count", 32'(count), 0);
        rst = 1'b0;
        tick();

        // Directed table: 0 -> 3 -> 1 -> 9 -> 9
        cfg_write(0, 0, 3);
        cfg_write(1, 1, 2);
        cfg_write(2, 2, 4);
        cfg_write(3, 3, 1);
        run_seq("t1", -1, 1'b0);
        check_eq("t1_final_count", 32'(count), 9);
        run_seq("t1_noise", -1, 1'b1);
        check_eq("t1_noise_final", 32'(count), 9);
        run_seq("t1_abort", 2, 1'b0);

        // start together with abort in IDLE does nothing
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_abort_busy", 32'(busy), 0);
        tick();
        check_eq("start_abort_busy2", 32'(busy), 0);

        // Wrap boundaries: 255 then 1
        cfg_write(0, 1, 1);
        cfg_write(1, 2, 1);
        cfg_write(2, 3, 0);
        cfg_write(3, 3, 0);
        run_seq("t2", -1, 1'b0);
        check_eq("t2_final_count", 32'(count), 1);

        // Reset mid-RUN clears outputs and the table at once
        cfg_write(0, 0, 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_count", 32'(count), 0);
        check_eq("midrst_phase", 32'(phase), 0);
        check_eq("midrst_done", 32'(done), 0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        run_seq("post_rst", -1, 1'b0);

        // Randomized tables, optional abort and noise
        for (int it = 0; it < 12; it++) begin
            int s_tot;
            for (int p = 0; p < PHASES; p++) cfg_write(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
            s_tot = total_steps();
            run_seq("rnd", ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, s_tot - 1)) : -1,
                    1'($urandom));
        end

`ifdef COUNTER_SEQ_LOOP_EN
        for (int p = 0; p < PHASES; p++) cfg_write(p, 0, 2);
        loop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            check_eq("loop_busy", 32'(busy), 1);
            check_eq("loop_done", 32'(done), (j % 8 == 0) ? 1 : 0);
            check_eq("loop_count", 32'(count), 32'(model_count(j)));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        loop  = 1'b0;
        check_eq("loop_abort_busy", 32'(busy), 0);
        check_eq("loop_abort_count", 32'(count), 32'(model_count(20)));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
